// File: rtl/sha256_msg_feeder_pkg.sv
// Shared SHA-256 constants and the message-feeder state encoding.
package sha256_msg_feeder_pkg;

  localparam int          WORDS_PER_BLOCK = 16;
  localparam int          ROUNDS          = 64;
  localparam logic [31:0] PAD_WORD        = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WAIT,
    RUN
  } feeder_state_t;

endpackage

// File: rtl/sha256_pad_word.sv
// Builds the final message word: keeps the valid leading bytes, appends the
// 0x80 marker byte right after them and zeroes the rest.
module sha256_pad_word
  import sha256_msg_feeder_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [2:0]  nbytes_i,
  output logic [31:0] word_o
);

  // NOTE: the output gets a default before the case so every path assigns it and no latch is inferred.
  always_comb begin
    word_o = data_i;
    case (nbytes_i)
      3'd0:    word_o = PAD_WORD;
      3'd1:    word_o = {data_i[31:24], 8'h80, 16'h0000};
      3'd2:    word_o = {data_i[31:16], 8'h80, 8'h00};
      3'd3:    word_o = {data_i[31:8], 8'h80};
      default: word_o = data_i;
    endcase
  end

endmodule

// File: rtl/sha256_msg_feeder.sv
// SHA-256 message front end: pads the byte stream, buffers each 512-bit block
// and plays it to the schedule-expansion unit as an unstalled 64-round sequence.
module sha256_msg_feeder
  import sha256_msg_feeder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic [2:0]  in_nbytes,
  output logic        in_ready,
  input  logic        core_ready,
  output logic [31:0] exp_word,
  output logic        exp_sel,
  output logic [5:0]  round_idx,
  output logic        blk_valid,
  output logic        blk_first,
  output logic        blk_last
);

  feeder_state_t state_q, state_d;
  logic [31:0]   blk_buf_q [WORDS_PER_BLOCK];
  logic [4:0]    wp_q, wp_d;
  logic [5:0]    k_q, k_d;
  logic [63:0]   len_q, len_d;
  logic          open_q, open_d;
  logic          pad_pend_q, pad_pend_d;
  logic          ovf_q, ovf_d;
  logic          first_q, first_d;

  logic          wr_en;
  logic [3:0]    wr_idx;
  logic [31:0]   wr_data;
  logic          handshake;
  logic [2:0]    nbytes_eff;
  logic [31:0]   in_word;
  logic [63:0]   len_add;
  logic          run;

  // Short counts only mean something on the last word; anything else is a full word.
  assign nbytes_eff = (!in_last || in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
  assign len_add    = in_last ? {58'd0, nbytes_eff, 3'b000} : 64'd32;
  assign in_ready   = (state_q == IDLE) || (state_q == FILL && open_q && !wp_q[4]);
  assign handshake  = in_valid && in_ready;

  sha256_pad_word u_pad_word (
    .data_i   (in_data),
    .nbytes_i (nbytes_eff),
    .word_o   (in_word)
  );

  always_comb begin
    state_d    = state_q;
    wp_d       = wp_q;
    k_d        = k_q;
    len_d      = len_q;
    open_d     = open_q;
    pad_pend_d = pad_pend_q;
    ovf_d      = ovf_q;
    first_d    = first_q;
    wr_en      = 1'b0;
    wr_idx     = wp_q[3:0];
    wr_data    = in_word;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          wr_en      = 1'b1;
          wr_idx     = 4'd0;
          wp_d       = 5'd1;
          len_d      = len_add;
          first_d    = 1'b1;
          open_d     = !in_last;
          pad_pend_d = in_last && (nbytes_eff == 3'd4);
          ovf_d      = 1'b0;
          state_d    = FILL;
        end
      end
      FILL: begin
        if (wp_q[4]) begin
          state_d = WAIT;
        end else if (open_q) begin
          if (handshake) begin
            wr_en = 1'b1;
            wp_d  = wp_q + 5'd1;
            len_d = len_q + len_add;
            if (in_last) begin
              open_d     = 1'b0;
              pad_pend_d = (nbytes_eff == 3'd4);
              ovf_d      = (nbytes_eff != 3'd4) && (wp_q >= 5'd14);
            end
          end
        end else begin
          // Closed message: one pad word per cycle; a marker at 14/15 leaves no room for the length.
          wr_en = 1'b1;
          wp_d  = wp_q + 5'd1;
          if (pad_pend_q) begin
            wr_data    = PAD_WORD;
            pad_pend_d = 1'b0;
            ovf_d      = (wp_q >= 5'd14);
          end else if (wp_q[3:0] == 4'd14) begin
            wr_data = ovf_q ? 32'd0 : len_q[63:32];
          end else if (wp_q[3:0] == 4'd15) begin
            wr_data = ovf_q ? 32'd0 : len_q[31:0];
          end else begin
            wr_data = 32'd0;
          end
        end
      end
      WAIT: begin
        if (core_ready) begin
          k_d     = 6'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        k_d = k_q + 6'd1;
        if (k_q == 6'(ROUNDS - 1)) begin
          wp_d  = 5'd0;
          ovf_d = 1'b0;
          if (open_q || pad_pend_q || ovf_q) begin
            first_d = 1'b0;
            state_d = FILL;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wp_q       <= '0;
      k_q        <= '0;
      len_q      <= '0;
      open_q     <= 1'b0;
      pad_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      first_q    <= 1'b0;
      // NOTE: the block buffer is deliberately reset so an aborted block never leaks into the next one.
      for (int i = 0; i < WORDS_PER_BLOCK; i++) blk_buf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      k_q        <= k_d;
      len_q      <= len_d;
      open_q     <= open_d;
      pad_pend_q <= pad_pend_d;
      ovf_q      <= ovf_d;
      first_q    <= first_d;
      if (wr_en) blk_buf_q[wr_idx] <= wr_data;
    end
  end

  assign run       = (state_q == RUN);
  assign blk_valid = run;
  assign round_idx = run ? k_q : 6'd0;
  assign exp_sel   = run && (k_q[5:4] != 2'b00);
  assign exp_word  = (run && k_q[5:4] == 2'b00) ? blk_buf_q[k_q[3:0]] : 32'd0;
  assign blk_first = run && first_q;
  assign blk_last  = run && !open_q && !pad_pend_q && !ovf_q;

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Directed bench for sha256_msg_feeder: known messages with hand-computed
// padded blocks, backpressure, asynchronous reset and back-to-back traffic.
module tb_sha256_msg_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic [2:0]  in_nbytes;
  logic        in_ready;
  logic        core_ready;
  logic [31:0] exp_word;
  logic        exp_sel;
  logic [5:0]  round_idx;
  logic        blk_valid;
  logic        blk_first;
  logic        blk_last;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] cap_w [16];
  logic        cap_first, cap_last, cap_seq_ok;
  int          cap_wait;

  logic [31:0] ew_abc [16];
  logic [31:0] ew_a   [16];
  logic [31:0] ew_b   [16];

  sha256_msg_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_nbytes  (in_nbytes),
    .in_ready   (in_ready),
    .core_ready (core_ready),
    .exp_word   (exp_word),
    .exp_sel    (exp_sel),
    .round_idx  (round_idx),
    .blk_valid  (blk_valid),
    .blk_first  (blk_first),
    .blk_last   (blk_last)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int t = 0;
    in_data   = d;
    in_last   = last;
    in_nbytes = nb;
    in_valid  = 1'b1;
    while (!in_ready && t < 400) begin
      step();
      t++;
    end
    check("in_ready_wait", in_ready, 1'b1);
    step();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_nbytes = 3'd4;
  endtask

  task automatic capture_block();
    int t = 0;
    cap_seq_ok = 1'b1;
    while (!blk_valid && t < 400) begin
      step();
      t++;
    end
    cap_wait = t;
    check("blk_start", blk_valid, 1'b1);
    cap_first = blk_first;
    cap_last  = blk_last;
    for (int k = 0; k < 64; k++) begin
      if (k < 16) cap_w[k] = exp_word;
      else if (exp_word !== 32'd0) cap_seq_ok = 1'b0;
      if (round_idx !== 6'(k) || exp_sel !== (k >= 16) || blk_valid !== 1'b1 ||
          blk_first !== cap_first || blk_last !== cap_last) cap_seq_ok = 1'b0;
      step();
    end
    check("blk_end", blk_valid, 1'b0);
  endtask

  task automatic expect_block(input string tag, input logic [31:0] ew [16],
                              input logic first, input logic last);
    capture_block();
    for (int i = 0; i < 16; i++) check($sformatf("%s_w%0d", tag, i), cap_w[i], ew[i]);
    check({tag, "_first"}, cap_first, first);
    check({tag, "_last"}, cap_last, last);
    check({tag, "_seq"}, cap_seq_ok, 1'b1);
  endtask

  initial begin
    logic seen;
    rst        = 1'b1;
    in_data    = '0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    in_nbytes  = 3'd4;
    core_ready = 1'b0;
    foreach (ew_abc[i]) ew_abc[i] = '0;
    ew_abc[0]  = 32'h6162_6380;
    ew_abc[15] = 32'h0000_0018;

    repeat (3) step();
    check("reset_outputs", {blk_valid, exp_sel, blk_first, blk_last, round_idx, exp_word}, 42'd0);
    rst = 1'b0;
    step();
    check("idle_outputs", {blk_valid, exp_sel, blk_first, blk_last, round_idx, exp_word}, 42'd0);
    check("idle_in_ready", in_ready, 1'b1);

    // "abc": single block, with latency from handshake to first round.
    core_ready = 1'b1;
    send_word(32'h6162_6300, 1'b1, 3'd3);
    check("abc_closed_in_ready", in_ready, 1'b0);
    expect_block("abc", ew_abc, 1'b1, 1'b1);
    check("abc_latency", cap_wait, 17);

    // Empty message: data bits must be masked away entirely.
    send_word(32'hDEAD_BEEF, 1'b1, 3'd0);
    foreach (ew_a[i]) ew_a[i] = '0;
    ew_a[0] = 32'h8000_0000;
    expect_block("empty", ew_a, 1'b1, 1'b1);

    // 56-byte message: marker lands at index 14, length spills into a pad-only block.
    for (int i = 0; i < 14; i++) send_word(32'h0101_0000 + 32'(i), i == 13, 3'd4);
    foreach (ew_a[i]) ew_a[i] = (i < 14) ? 32'h0101_0000 + 32'(i) : 32'd0;
    ew_a[14] = 32'h8000_0000;
    foreach (ew_b[i]) ew_b[i] = '0;
    ew_b[15] = 32'h0000_01C0;
    expect_block("m56_b1", ew_a, 1'b1, 1'b0);
    expect_block("m56_b2", ew_b, 1'b0, 1'b1);

    // Oversized byte count on a last word counts as 4.
    send_word(32'h1122_3344, 1'b1, 3'd7);
    foreach (ew_a[i]) ew_a[i] = '0;
    ew_a[0]  = 32'h1122_3344;
    ew_a[1]  = 32'h8000_0000;
    ew_a[15] = 32'h0000_0020;
    expect_block("nb7", ew_a, 1'b1, 1'b1);

    // Backpressure: the block sits in WAIT until core_ready rises.
    core_ready = 1'b0;
    send_word(32'h6162_6300, 1'b1, 3'd3);
    repeat (40) step();
    check("bp_blk_valid", blk_valid, 1'b0);
    check("bp_in_ready", in_ready, 1'b0);
    core_ready = 1'b1;
    step();
    check("bp_release", {blk_valid, round_idx}, {1'b1, 6'd0});
    expect_block("bp", ew_abc, 1'b1, 1'b1);

    // Reset in the middle of a block, then a clean "abc".
    send_word(32'h6162_6300, 1'b1, 3'd3);
    begin
      int t = 0;
      while (!(blk_valid && round_idx == 6'd30) && t < 400) begin
        step();
        t++;
      end
    end
    check("k30_reached", {blk_valid, round_idx}, {1'b1, 6'd30});
    #1 rst = 1'b1;
    #1;
    check("rst_async", {blk_valid, exp_sel, blk_first, blk_last, round_idx, exp_word}, 42'd0);
    repeat (2) step();
    rst = 1'b0;
    step();
    send_word(32'h6162_6300, 1'b1, 3'd3);
    expect_block("post_rst", ew_abc, 1'b1, 1'b1);

    // Back-to-back: 20 words with random bubbles, then "abc".
    foreach (ew_a[i]) ew_a[i] = 32'hA500_0000 + 32'(i);
    foreach (ew_b[i]) ew_b[i] = (i < 4) ? 32'hA500_0010 + 32'(i) : 32'd0;
    ew_b[4]  = 32'h8000_0000;
    ew_b[15] = 32'h0000_0280;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(0, 3)) step();
          send_word(32'hA500_0000 + 32'(i), i == 19, (i == 0) ? 3'd1 : 3'd4);
        end
        step();
        send_word(32'h6162_6300, 1'b1, 3'd3);
      end
      begin
        expect_block("b2b_1", ew_a, 1'b1, 1'b0);
        expect_block("b2b_2", ew_b, 1'b0, 1'b1);
        expect_block("b2b_3", ew_abc, 1'b1, 1'b1);
      end
    join
    seen = 1'b0;
    repeat (80) begin
      step();
      if (blk_valid) seen = 1'b1;
    end
    check("no_extra_block", seen, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
